mult_share_arbiter: RTL
=======================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one 8x8 serial multiplier between NREQ requesters. Sequences the multiplier's
//  rst/Product_Valid protocol and returns each product tagged with the requester id.
//  Round-robin arbitration; one operation in flight at a time.
// PARAMETERS
//  NREQ     4   number of requesters (2..8); IDW = $clog2(NREQ)
//  TIMEOUT  16  WAIT-state cycle limit (used only with MULT_TIMEOUT_EN)
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous reset, active-high
//  req          in   NREQ     request per requester; level, held until gnt
//  in_a_flat    in   8*NREQ   multiplicand of requester i at [8i+7:8i]
//  in_b_flat    in   8*NREQ   multiplier of requester i at [8i+7:8i]
//  gnt          out  NREQ     one-hot, one-cycle pulse: request accepted, operands captured
//  busy         out  1        high in WAIT and DONE
//  rsp_valid    out  1        one-cycle pulse: rsp_id/rsp_product valid
//  rsp_id       out  IDW      index of requester that owns the response
//  rsp_product  out  16       unsigned product
//  rsp_err      out  1        timeout flag, qualified by rsp_valid (MULT_TIMEOUT_EN only)
//  mul_rst      out  1        drives multiplier rst; high holds it idle
//  mul_a        out  8        drives multiplier in_a
//  mul_b        out  8        drives multiplier in_b
//  mul_product  in   16       from multiplier Product
//  mul_valid    in   1        from multiplier Product_Valid
// BEHAVIOUR
//  - Reset: state=IDLE, gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_product=0, rsp_err=0,
//    mul_rst=1, mul_a=0, mul_b=0, rr_ptr=0. Reset mid-op drops the op: no rsp is issued.
//  - All outputs registered.
//  - FSM states: IDLE, WAIT, DONE.
//  - IDLE, any req: winner = first set bit searching from rr_ptr upward, wrapping.
//    Same edge: gnt[winner]<=1, mul_a/mul_b<=winner operands, id latched, mul_rst<=0,
//    rr_ptr<=winner+1 (mod NREQ), state<=WAIT. No req: stay IDLE, mul_rst stays 1.
//  - WAIT: mul_a/mul_b held stable. On mul_valid=1: rsp_product<=mul_product,
//    rsp_id<=latched id, rsp_valid<=1, mul_rst<=1, state<=DONE.
//  - DONE: one cycle; rsp_valid<=0, state<=IDLE. No grant is issued in DONE.
//  - mul_valid outside WAIT is ignored: the multiplier's free-running counter is held by mul_rst.
//  - Timing: gnt at edge E0; multiplier loads at E1; mul_valid rises at E10; rsp_valid rises at E11.
//    Next gnt no earlier than E13. Throughput is 1 op per 13 cycles.
//  - A requester must deassert req the cycle after its gnt; otherwise it is re-arbitrated.
//  - Operands are sampled only at the grant edge; later changes are ignored.
//  - A requester with req=0 is skipped; rr_ptr advances only on a grant.
// CONFIGURATION
//  MULT_TIMEOUT_EN defined:
//    - A cycle counter is cleared on entry to WAIT.
//    - If TIMEOUT cycles elapse in WAIT with no mul_valid: rsp_valid<=1, rsp_err<=1,
//      rsp_product<=0, mul_rst<=1, state<=DONE.
//    - rsp_err is 0 on normal completion. mul_valid in the same cycle as the timeout wins
//      (normal completion).
//  MULT_TIMEOUT_EN undefined:
//    - No counter; WAIT lasts until mul_valid.
//    - The rsp_err port is present and tied to 0.
// TESTING
//  1 Single: req=4'b0001, a=8'd12, b=8'd13 -> gnt=0001 for 1 cycle;
//    11 cycles later rsp_valid=1, rsp_id=0, rsp_product=16'd156.
//  2 Round-robin: req=4'b1111 held, re-raised after each gnt -> grants in order 0,1,2,3,0;
//    each rsp_id matches its grant.
//  3 Extremes: a=8'hFF, b=8'hFF -> 16'hFE01; a=8'h00, b=8'hA5 -> 16'h0000;
//    a=8'h80, b=8'h02 -> 16'h0100.
//  4 Skip and wrap: rr_ptr=3, req=4'b0100 -> gnt=0100 and rr_ptr becomes 3;
//    next req=4'b1001 -> gnt=1000.
//  5 Reset mid-op: assert rst 5 cycles after gnt -> no rsp_valid; all outputs at reset
//    values; mul_rst=1. A fresh request then completes normally.
//  6 Timeout (MULT_TIMEOUT_EN, TIMEOUT=16): stub holds mul_valid=0 -> rsp_valid=1,
//    rsp_err=1, rsp_product=0 on the 17th WAIT edge; FSM then returns to IDLE.

Source files
------------

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : mult_share_arbiter
// Purpose  : Round-robin sharing of one 8x8 serial multiplier between NREQ
//            requesters. Sequences the multiplier rst/Product_Valid handshake
//            and returns each product tagged with the owning requester id.
//            One operation in flight at a time; every output is registered.
// Options  : MULT_TIMEOUT_EN - enables a WAIT-state watchdog of TIMEOUT cycles
//            that completes the operation with rsp_err_o=1 and a zero product.
// Revision : 1.0 - initial release
// =============================================================================
module mult_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] in_a_flat_i,
  input  logic [8*NREQ-1:0] in_b_flat_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic              busy_o,
  output logic              rsp_valid_o,
  output logic [IDW-1:0]    rsp_id_o,
  output logic [15:0]       rsp_product_o,
  output logic              rsp_err_o,
  output logic              mul_rst_o,
  output logic [7:0]        mul_a_o,
  output logic [7:0]        mul_b_o,
  input  logic [15:0]       mul_product_i,
  input  logic              mul_valid_i
);

  // Reject unsupported configurations at elaboration time.
  generate
    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
      $error("mult_share_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,       state_d;
  logic [NREQ-1:0]  gnt_q,         gnt_d;
  logic             busy_q,        busy_d;
  logic             rsp_valid_q,   rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q,      rsp_id_d;
  logic [15:0]      rsp_product_q, rsp_product_d;
  logic             mul_rst_q,     mul_rst_d;
  logic [7:0]       mul_a_q,       mul_a_d;
  logic [7:0]       mul_b_q,       mul_b_d;
  logic [IDW-1:0]   rr_ptr_q,      rr_ptr_d;
  logic [IDW-1:0]   id_q,          id_d;

`ifdef MULT_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);
  logic [CNTW-1:0]  cnt_q,         cnt_d;
  logic             rsp_err_q,     rsp_err_d;
`endif

  // Winner search: first asserted request at or above rr_ptr, wrapping round.
  logic             win_found;
  logic [IDW-1:0]   win_idx;
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!win_found && req_i[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/WAIT/DONE sequencer.
  always_comb begin
    state_d       = state_q;
    gnt_d         = '0;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    mul_rst_d     = mul_rst_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
`ifdef MULT_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_err_d     = rsp_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d[win_idx] = 1'b1;
          mul_a_d        = in_a_flat_i[int'(win_idx)*8 +: 8];
          mul_b_d        = in_b_flat_i[int'(win_idx)*8 +: 8];
          id_d           = win_idx;
          mul_rst_d      = 1'b0;
          rr_ptr_d       = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          state_d        = S_WAIT;
`ifdef MULT_TIMEOUT_EN
          cnt_d          = '0;
`endif
        end
      end
      S_WAIT: begin
        // A product arriving on the same edge as the timeout still wins.
        if (mul_valid_i) begin
          rsp_product_d = mul_product_i;
          rsp_id_d      = id_q;
          rsp_valid_d   = 1'b1;
          mul_rst_d     = 1'b1;
          state_d       = S_DONE;
`ifdef MULT_TIMEOUT_EN
          rsp_err_d     = 1'b0;
`endif
        end
`ifdef MULT_TIMEOUT_EN
        else if (cnt_q == CNTW'(TIMEOUT)) begin
          rsp_product_d = 16'h0000;
          rsp_id_d      = id_q;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          mul_rst_d     = 1'b1;
          state_d       = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mul_rst_d = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      gnt_q         <= '0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= 16'h0000;
      mul_rst_q     <= 1'b1;
      mul_a_q       <= 8'h00;
      mul_b_q       <= 8'h00;
      rr_ptr_q      <= '0;
      id_q          <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
      mul_rst_q     <= mul_rst_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
    end
  end

`ifdef MULT_TIMEOUT_EN
  // Watchdog counter and error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  assign gnt_o         = gnt_q;
  assign busy_o        = busy_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_id_o      = rsp_id_q;
  assign rsp_product_o = rsp_product_q;
  assign mul_rst_o     = mul_rst_q;
  assign mul_a_o       = mul_a_q;
  assign mul_b_o       = mul_b_q;

endmodule
`default_nettype wire
